// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared definitions for the instruction-fetch stage:
//   DEF_ADDR_W   : default PC / instruction-memory word-address width
//   DEF_DATA_W   : default instruction width
//   DEF_RESET_PC : default PC loaded on reset
//   fetch_entry_t: one fetch-buffer entry, {pc, instr}
package fetch_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = '0;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
// DEPTH-entry synchronous FIFO holding fetched {pc, instr} entries.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   push_i       : write push_data_i at the tail this edge
//   push_data_i  : entry to write
//   pop_i        : drop the head entry this edge (ignored when empty)
//   flush_i      : empty the FIFO this edge; wins over push and pop
//   count_o      : number of valid entries (registered)
//   head_o       : oldest entry; stale contents when count_o == 0
// The producer guarantees push_i is never asserted while full without a
// simultaneous pop, so there is no overflow guard here.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  entry_t           push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] count_o,
  output entry_t           head_o
);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  // Pointer increment that wraps at DEPTH so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign do_pop = pop_i && (count_q != '0);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push_i, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push_i && !flush_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction-fetch stage in front of a registered instruction memory.
// Owns the PC, issues one word address per cycle while buffer space allows,
// captures the returned instruction one cycle later and queues {pc, instr}
// for decode.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   im_addr         : word address to instruction memory (= PC register)
//   im_instr        : instruction memory data, valid the cycle after im_addr
//                     was sampled
//   redirect_valid  : load redirect_pc, squash in-flight fetch, flush buffer
//   redirect_pc     : redirect target
//   out_valid/out_ready : decode handshake. An entry transfers on an edge
//                     where out_valid && out_ready. out_valid never depends on
//                     out_ready, and once raised the head entry stays stable
//                     until it is accepted or a redirect/reset discards it.
//   out_instr/out_pc: head entry contents
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [DATA_W-1:0] im_instr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;

  logic [CNT_W-1:0]  count;
  entry_t            head;
  entry_t            push_entry;
  logic              pop;
  logic              push;
  logic              issue;
  logic [CNT_W:0]    in_use;

  assign pop = out_valid && out_ready;

  // Slots that will be occupied after this edge if nothing new is issued:
  // buffered entries plus the fetch in flight, minus the one leaving.
  // Issuing only while this is below DEPTH means the capture of every
  // issued fetch always finds a free slot.
  assign in_use = {1'b0, count} + (CNT_W + 1)'(req_q) - (CNT_W + 1)'(pop);
  assign issue  = !redirect_valid && (in_use < (CNT_W + 1)'(DEPTH));

  // A redirect squashes the fetch whose data arrives this cycle.
  assign push       = req_q && !redirect_valid;
  assign push_entry = '{pc: req_pc_q, instr: im_instr};

  always_comb begin
    pc_d     = pc_q;
    req_d    = 1'b0;
    req_pc_d = req_pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (issue) begin
      req_d    = 1'b1;
      req_pc_d = pc_q;
      pc_d     = pc_q + ADDR_W'(1);  // wraps modulo 2^ADDR_W
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      req_pc_q <= '0;
    end else begin
      pc_q     <= pc_d;
      req_q    <= req_d;
      req_pc_q <= req_pc_d;
    end
  end

  // A pop coinciding with a redirect is still a completed transfer from
  // decode's point of view; the flush simply discards everything behind it.
  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .count_o     (count),
    .head_o      (head)
  );

  assign im_addr   = pc_q;
  assign out_valid = (count != '0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Directed bench for fetch_unit with a registered memory model that returns
// instr = addr + 0x100. Inputs change on the falling edge; outputs are
// checked on the falling edge after each rising edge.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] im_addr;
  logic [31:0] im_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int checks = 0;
  int errors = 0;

  fetch_unit #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_PC (32'h0),
    .DEPTH    (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .im_addr        (im_addr),
    .im_instr       (im_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered instruction memory model
  always @(posedge clk) begin
    im_instr <= im_addr + 32'h100;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] exp_pc);
    logic [31:0] exp_instr;
    exp_instr = exp_pc + 32'h100;
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".pc"}, 64'(out_pc), 64'(exp_pc));
    chk({tag, ".instr"}, 64'(out_instr), 64'(exp_instr));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n          = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Reset state
    #1;
    chk("rst.im_addr", 64'(im_addr), 64'h0);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.out_instr", 64'(out_instr), 64'h0);
    chk("rst.out_pc", 64'(out_pc), 64'h0);

    @(negedge clk);
    rst_n = 1'b1;

    // E1: pc 0 issued, nothing visible yet
    tick();
    chk("e1.out_valid", 64'(out_valid), 64'd0);
    chk("e1.im_addr", 64'(im_addr), 64'h1);

    // E2: first entry visible
    tick();
    chk_head("first", 32'h0);
    chk("e2.im_addr", 64'(im_addr), 64'h2);

    // Backpressure for 5 cycles: two entries held, PC frozen at 2
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp.im_addr", 64'(im_addr), 64'h2);
      chk_head("bp.head", 32'h0);
    end

    // Release: pc 0 leaves, then 1, 2 follow without drop or duplicate
    out_ready = 1'b1;
    tick();
    chk_head("rel1", 32'h1);
    chk("rel1.im_addr", 64'(im_addr), 64'h3);
    tick();
    chk_head("rel2", 32'h2);
    chk("rel2.im_addr", 64'(im_addr), 64'h4);

    // Redirect to 0x40 with pc 2 buffered and pc 3 in flight
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    chk("redir.r.out_valid", 64'(out_valid), 64'd0);
    chk("redir.r.im_addr", 64'(im_addr), 64'h40);
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    tick();
    chk("redir.r1.out_valid", 64'(out_valid), 64'd0);
    chk("redir.r1.im_addr", 64'(im_addr), 64'h41);
    tick();
    chk_head("redir.r2", 32'h40);
    tick();
    chk_head("redir.s1", 32'h41);
    tick();
    chk_head("redir.s2", 32'h42);

    // Redirect with head 0x42 accepted on the same edge; target wraps
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    tick();
    chk("rpop.out_valid", 64'(out_valid), 64'd0);
    chk("rpop.im_addr", 64'(im_addr), 64'hFFFF_FFFF);
    redirect_valid = 1'b0;
    tick();
    chk("wrap.r1.out_valid", 64'(out_valid), 64'd0);
    chk("wrap.r1.im_addr", 64'(im_addr), 64'h0);
    tick();
    chk_head("wrap.a", 32'hFFFF_FFFF);
    tick();
    chk_head("wrap.b", 32'h0);
    tick();
    chk_head("wrap.c", 32'h1);

    // Fill to two entries, then async reset between edges
    out_ready = 1'b0;
    tick();
    chk_head("prerst", 32'h1);
    chk("prerst.im_addr", 64'(im_addr), 64'h3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.out_valid", 64'(out_valid), 64'd0);
    chk("arst.im_addr", 64'(im_addr), 64'h0);
    chk("arst.out_pc", 64'(out_pc), 64'h0);
    chk("arst.out_instr", 64'(out_instr), 64'h0);

    // Restart from RESET_PC
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("rs.e1.out_valid", 64'(out_valid), 64'd0);
    chk("rs.e1.im_addr", 64'(im_addr), 64'h1);
    tick();
    chk_head("rs.a", 32'h0);
    tick();
    chk_head("rs.b", 32'h1);
    tick();
    chk_head("rs.c", 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
